// File: rtl/cbf_recursion_bank.sv
// Time-multiplexed bank of N complex first-order recursions s_k <= lambda_k*s_k +/- gamma_k.
// One shared complex multiplier steps through the channels; the real parts are summed into out.
module cbf_recursion_bank #(
  parameter int N      = 3,
  parameter int DATA_W = 32,
  parameter int COEF_W = 16,
  parameter int FRAC   = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     clear,
  input  logic                     cfg_we,
  input  logic [$clog2(N)+1:0]     cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_data,
  output logic signed [DATA_W-1:0] out,
  output logic                     out_valid
);

  localparam int AW  = $clog2(N) + 2;
  localparam int CIW = (N > 1) ? $clog2(N) : 1;
  localparam int WW  = DATA_W + COEF_W + 2;
  localparam int ACW = DATA_W + $clog2(N) + 1;

  localparam logic signed [WW-1:0]  RND    = WW'(1) << (FRAC - 1);
  localparam logic signed [WW-1:0]  SMAX_W = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WW-1:0]  SMIN_W = {{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACW-1:0] SMAX_A = {{(ACW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACW-1:0] SMIN_A = {{(ACW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic signed [COEF_W-1:0] lr [N];
  logic signed [COEF_W-1:0] li [N];
  logic signed [COEF_W-1:0] g  [N];
  logic signed [DATA_W-1:0] sr [N];
  logic signed [DATA_W-1:0] si [N];

  logic [CIW-1:0]          c;
  logic [N-1:0]            smp;
  logic signed [ACW-1:0]   acc;
  logic                    accept;

  logic [AW-1:0]           cfg_ch;
  logic [1:0]              cfg_reg;
  logic                    cfg_ok;

  logic signed [WW-1:0]     lr_w, li_w, g_w, sr_w, si_w;
  logic signed [WW-1:0]     pr_full, pi_full, pr_rnd, pi_rnd, nr_w, ni_w;
  logic signed [DATA_W-1:0] nr, ni, acc_sat;
  logic signed [ACW-1:0]    nr_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // clear wins over in_valid: the sample offered alongside a clear is not taken
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !clear) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY:    if (c == CIW'(N - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign cfg_ch  = cfg_addr >> 2;
  assign cfg_reg = cfg_addr[1:0];
  assign cfg_ok  = cfg_we && (state == IDLE) && (cfg_reg != 2'd3) && (cfg_ch < AW'(N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        lr[k] <= '0;
        li[k] <= '0;
        g[k]  <= '0;
      end
    end else if (cfg_ok) begin
      for (int k = 0; k < N; k++) begin
        if (cfg_ch == AW'(k)) begin
          case (cfg_reg)
            2'd0:    lr[k] <= cfg_data;
            2'd1:    li[k] <= cfg_data;
            2'd2:    g[k]  <= cfg_data;
            default: ;
          endcase
        end
      end
    end
  end

  // shared complex multiplier, round-half-up, then saturate each component
  always_comb begin
    lr_w    = lr[c];
    li_w    = li[c];
    g_w     = g[c];
    sr_w    = sr[c];
    si_w    = si[c];
    pr_full = lr_w * sr_w - li_w * si_w;
    pi_full = lr_w * si_w + li_w * sr_w;
    pr_rnd  = (pr_full + RND) >>> FRAC;
    pi_rnd  = (pi_full + RND) >>> FRAC;
    nr_w    = smp[c] ? (pr_rnd + g_w) : (pr_rnd - g_w);
    ni_w    = pi_rnd;
    nr      = (nr_w > SMAX_W) ? DMAX : (nr_w < SMIN_W) ? DMIN : nr_w[DATA_W-1:0];
    ni      = (ni_w > SMAX_W) ? DMAX : (ni_w < SMIN_W) ? DMIN : ni_w[DATA_W-1:0];
    nr_a    = nr;
    acc_sat = (acc > SMAX_A) ? DMAX : (acc < SMIN_A) ? DMIN : acc[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        sr[k] <= '0;
        si[k] <= '0;
      end
      c         <= '0;
      smp       <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE && clear) begin
        for (int k = 0; k < N; k++) begin
          sr[k] <= '0;
          si[k] <= '0;
        end
      end
      if (accept) begin
        smp <= in;
        acc <= '0;
        c   <= '0;
      end
      if (state == BUSY) begin
        sr[c] <= nr;
        si[c] <= ni;
        acc   <= acc + nr_a;
        c     <= c + CIW'(1);
      end
      if (state == DONE) begin
        out       <= acc_sat;
        out_valid <= 1'b1;
      end
    end
  end

endmodule
